// File: rtl/plat_collide_scan_if.sv
// rtl/plat_collide_scan_if.sv - request/response bundle for the platform collision scanner
// Purpose: groups the query handshake, character state, packed platform lists and
//   the landing result into one bundle.
// Modports:
//   master - query source / result consumer (physics side)
//   slave  - plat_collide_scan
// Signals: req_valid/req_ready, char_x, char_y, prev_y, camera_y, plat_relative_x,
//   plat_relative_y, plat_len, block_switch, resp_valid/resp_ready, landed,
//   floor_hit, hit_idx, land_y, and ceil_hit when PLAT_COLLIDE_CEIL_EN is defined.
interface plat_collide_scan_if #(
  parameter int PLATFORM_NUM_PER_BLOCK = 7,
  parameter int PHY_WIDTH              = 16,
  parameter int BLOCK_LEN_WIDTH        = 4,
  parameter int CAMERA_WIDTH           = 6
);
  logic                                          req_valid;
  logic                                          req_ready;
  logic signed [PHY_WIDTH:0]                     char_x;
  logic signed [PHY_WIDTH:0]                     char_y;
  logic signed [PHY_WIDTH:0]                     prev_y;
  logic [CAMERA_WIDTH-1:0]                       camera_y;
  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]   plat_relative_x;
  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]   plat_relative_y;
  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len;
  logic                                          block_switch;
  logic                                          resp_valid;
  logic                                          resp_ready;
  logic                                          landed;
  logic                                          floor_hit;
  logic [2:0]                                    hit_idx;
  logic signed [PHY_WIDTH:0]                     land_y;
`ifdef PLAT_COLLIDE_CEIL_EN
  logic                                          ceil_hit;

  modport master (
    output req_valid, char_x, char_y, prev_y, camera_y,
           plat_relative_x, plat_relative_y, plat_len, block_switch, resp_ready,
    input  req_ready, resp_valid, landed, floor_hit, hit_idx, land_y, ceil_hit
  );

  modport slave (
    input  req_valid, char_x, char_y, prev_y, camera_y,
           plat_relative_x, plat_relative_y, plat_len, block_switch, resp_ready,
    output req_ready, resp_valid, landed, floor_hit, hit_idx, land_y, ceil_hit
  );
`else
  modport master (
    output req_valid, char_x, char_y, prev_y, camera_y,
           plat_relative_x, plat_relative_y, plat_len, block_switch, resp_ready,
    input  req_ready, resp_valid, landed, floor_hit, hit_idx, land_y
  );

  modport slave (
    input  req_valid, char_x, char_y, prev_y, camera_y,
           plat_relative_x, plat_relative_y, plat_len, block_switch, resp_ready,
    output req_ready, resp_valid, landed, floor_hit, hit_idx, land_y
  );
`endif
endinterface

// File: rtl/plat_collide_scan.sv
// rtl/plat_collide_scan.sv - sequential landing/collision scanner over one block's platforms
// Purpose: per query, walks the current block's platforms one per cycle and reports
//   whether the character crossed a platform top while moving down (highest top
//   wins, lower index on ties), falling back to the absolute floor at Y=0.
// Ports:
//   sys_clk - system clock
//   sys_rst - synchronous active-high reset
//   bus     - plat_collide_scan_if.slave (query in, result out)
// Optional: define PLAT_COLLIDE_CEIL_EN to add bus.ceil_hit, a head-bump flag
//   raised when a rising character's head crosses a platform underside.
// Timing: result is presented N+1 clocks after the accepting edge (N scan cycles
//   plus one finalize cycle) and held until resp_ready.
module plat_collide_scan #(
  parameter int PLATFORM_NUM_PER_BLOCK = 7,
  parameter int PHY_WIDTH              = 16,
  parameter int BLOCK_LEN_WIDTH        = 4,
  parameter int CAMERA_WIDTH           = 6,
  parameter int BLOCK_WIDTH            = 480,
  parameter int TILE_WIDTH             = 10,
  parameter int CHAR_WIDTH             = 16
`ifdef PLAT_COLLIDE_CEIL_EN
  ,
  parameter int PLAT_THICK             = 4
`endif
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  plat_collide_scan_if.slave bus
);
  localparam int W     = PHY_WIDTH + 1;
  localparam int IDX_W = $clog2(PLATFORM_NUM_PER_BLOCK + 1);
  // idx == N is the finalize cycle; platforms occupy idx 0..N-1
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PLATFORM_NUM_PER_BLOCK);
  localparam logic [2:0]       IDX_NONE = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic signed [W:0] CW_E   = (W+1)'(CHAR_WIDTH);
  localparam logic signed [W:0] ZERO_E = '0;

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic signed [W-1:0]     cx_q, cy_q, py_q;
  logic [CAMERA_WIDTH-1:0] cam_q;

  logic                    best_hit;
  logic signed [W-1:0]     best_top;
  logic [2:0]              best_idx;

  logic                    resp_valid_q, landed_q, floor_q;
  logic [2:0]              hit_idx_q;
  logic signed [W-1:0]     land_y_q;

  // Current platform fields
  logic [PHY_WIDTH-1:0]       cur_x, cur_y;
  logic [BLOCK_LEN_WIDTH-1:0] cur_len;

  always_comb begin
    cur_x   = '0;
    cur_y   = '0;
    cur_len = '0;
    for (int i = 0; i < PLATFORM_NUM_PER_BLOCK; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_x   = bus.plat_relative_x[i*PHY_WIDTH +: PHY_WIDTH];
        cur_y   = bus.plat_relative_y[i*PHY_WIDTH +: PHY_WIDTH];
        cur_len = bus.plat_len[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
      end
    end
  end

  // Geometry wraps at W bits; comparisons use one extra bit so char+width cannot wrap
  logic [W-1:0]        base_u, top_u, right_u;
  logic signed [W:0]   top_e, right_e, relx_e, cx_e, cy_e, py_e;
  logic                x_ovl, land_hit, better;

  assign base_u  = W'(cam_q) * W'(BLOCK_WIDTH);
  assign top_u   = base_u + W'(cur_y);
  assign right_u = W'(cur_x) + W'(cur_len) * W'(TILE_WIDTH);

  assign top_e   = {top_u[W-1], top_u};
  assign right_e = {right_u[W-1], right_u};
  assign relx_e  = {2'b00, cur_x};
  assign cx_e    = {cx_q[W-1], cx_q};
  assign cy_e    = {cy_q[W-1], cy_q};
  assign py_e    = {py_q[W-1], py_q};

  assign x_ovl    = (cur_len != '0) && (cx_e + CW_E > relx_e) && (cx_e < right_e);
  assign land_hit = x_ovl && (py_e >= top_e) && (cy_e <= top_e);
  // Strict compare keeps the earlier (lower) index on equal tops
  assign better   = !best_hit || ($signed(top_u) > best_top);

`ifdef PLAT_COLLIDE_CEIL_EN
  localparam logic signed [W:0] THK_E = (W+1)'(PLAT_THICK);
  logic signed [W:0] ceil_line;
  logic              ceil_cand, ceil_acc, ceil_q;

  assign ceil_line = top_e - THK_E;
  assign ceil_cand = x_ovl && (py_e < cy_e) && (py_e + CW_E <= ceil_line) &&
                     (cy_e + CW_E > ceil_line);
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      py_q         <= '0;
      cam_q        <= '0;
      best_hit     <= 1'b0;
      best_top     <= '0;
      best_idx     <= IDX_NONE;
      resp_valid_q <= 1'b0;
      landed_q     <= 1'b0;
      floor_q      <= 1'b0;
      hit_idx_q    <= IDX_NONE;
      land_y_q     <= '0;
`ifdef PLAT_COLLIDE_CEIL_EN
      ceil_acc     <= 1'b0;
      ceil_q       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cx_q     <= bus.char_x;
            cy_q     <= bus.char_y;
            py_q     <= bus.prev_y;
            cam_q    <= bus.camera_y;
            best_hit <= 1'b0;
            best_top <= '0;
            best_idx <= IDX_NONE;
            idx      <= '0;
`ifdef PLAT_COLLIDE_CEIL_EN
            ceil_acc <= 1'b0;
`endif
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (bus.block_switch) begin
            // New lists: rescan from the start against the new block index
            cam_q    <= bus.camera_y;
            best_hit <= 1'b0;
            best_top <= '0;
            best_idx <= IDX_NONE;
            idx      <= '0;
`ifdef PLAT_COLLIDE_CEIL_EN
            ceil_acc <= 1'b0;
`endif
          end else if (idx == IDX_LAST) begin
            resp_valid_q <= 1'b1;
            if (best_hit) begin
              landed_q  <= 1'b1;
              floor_q   <= 1'b0;
              hit_idx_q <= best_idx;
              land_y_q  <= best_top;
            end else begin
              landed_q  <= (cy_e <= ZERO_E);
              floor_q   <= (cy_e <= ZERO_E);
              hit_idx_q <= IDX_NONE;
              land_y_q  <= '0;
            end
`ifdef PLAT_COLLIDE_CEIL_EN
            ceil_q <= ceil_acc;
`endif
            state <= ST_DONE;
          end else begin
            if (land_hit && better) begin
              best_hit <= 1'b1;
              best_top <= $signed(top_u);
              best_idx <= 3'(idx);
            end
`ifdef PLAT_COLLIDE_CEIL_EN
            if (ceil_cand) ceil_acc <= 1'b1;
`endif
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.landed     = landed_q;
  assign bus.floor_hit  = floor_q;
  assign bus.hit_idx    = hit_idx_q;
  assign bus.land_y     = land_y_q;
`ifdef PLAT_COLLIDE_CEIL_EN
  assign bus.ceil_hit   = ceil_q;
`endif

endmodule

// File: tb/tb_plat_collide_scan.sv
// tb/tb_plat_collide_scan.sv - self-checking bench for plat_collide_scan
module tb_plat_collide_scan;
  logic sys_clk = 1'b0;
  logic sys_rst;

  plat_collide_scan_if bus ();

  plat_collide_scan dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Query scenario as plain integers
  int m_px[7], m_py[7], m_pl[7];
  int m_cam, m_cx, m_cy, m_prev;

  // Expected result
  int e_land, e_floor, e_idx, e_y, e_ceil;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: landing = downward crossing of a platform top within horizontal reach
  task automatic model();
    int best, btop, top, right;
    bit ov;
    best   = -1;
    btop   = 0;
    e_ceil = 0;
    for (int i = 0; i < 7; i++) begin
      top   = m_cam * 480 + m_py[i];
      right = m_px[i] + m_pl[i] * 10;
      ov    = (m_pl[i] != 0) && (m_cx + 16 > m_px[i]) && (m_cx < right);
      if (ov && m_prev >= top && m_cy <= top && (best < 0 || top > btop)) begin
        best = i;
        btop = top;
      end
      if (ov && m_prev < m_cy && m_prev + 16 <= top - 4 && m_cy + 16 > top - 4)
        e_ceil = 1;
    end
    if (best >= 0) begin
      e_land = 1; e_floor = 0; e_idx = best; e_y = btop;
    end else if (m_cy <= 0) begin
      e_land = 1; e_floor = 1; e_idx = 7; e_y = 0;
    end else begin
      e_land = 0; e_floor = 0; e_idx = 7; e_y = 0;
    end
  endtask

  task automatic clear_lists();
    for (int i = 0; i < 7; i++) begin
      m_px[i] = 0; m_py[i] = 0; m_pl[i] = 0;
    end
  endtask

  task automatic drive_lists();
    for (int i = 0; i < 7; i++) begin
      bus.plat_relative_x[i*16 +: 16] = 16'(m_px[i]);
      bus.plat_relative_y[i*16 +: 16] = 16'(m_py[i]);
      bus.plat_len[i*4 +: 4]          = 4'(m_pl[i]);
    end
    bus.camera_y = 6'(m_cam);
  endtask

  // Drive a query and let it be accepted; returns 1 time unit after the accepting edge
  task automatic start_query();
    @(negedge sys_clk);
    drive_lists();
    bus.char_x    = 17'(m_cx);
    bus.char_y    = 17'(m_cy);
    bus.prev_y    = 17'(m_prev);
    bus.req_valid = 1'b1;
    check("req_ready_idle", bus.req_ready, 1);
    @(posedge sys_clk); #1;
    bus.req_valid = 1'b0;
    // Character state must have been latched
    bus.char_x = 17'($urandom);
    bus.char_y = 17'($urandom);
    bus.prev_y = 17'($urandom);
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge sys_clk); #1;
      n++;
      if (bus.resp_valid === 1'b1) break;
    end
    check(tag, n, 8);
  endtask

  task automatic check_result(input string tag);
    model();
    check({tag, ".landed"},  bus.landed,    e_land);
    check({tag, ".floor"},   bus.floor_hit, e_floor);
    check({tag, ".hit_idx"}, bus.hit_idx,   e_idx);
    check({tag, ".land_y"},  bus.land_y,    e_y);
`ifdef PLAT_COLLIDE_CEIL_EN
    check({tag, ".ceil"},    bus.ceil_hit,  e_ceil);
`endif
  endtask

  task automatic release_resp();
    bus.resp_ready = 1'b1;
    @(posedge sys_clk); #1;
    bus.resp_ready = 1'b0;
    check("resp_valid_drop", bus.resp_valid, 0);
    check("req_ready_back",  bus.req_ready,  1);
  endtask

  task automatic do_query(input string tag);
    start_query();
    wait_resp({tag, ".latency"});
    check_result(tag);
    release_resp();
  endtask

  initial begin
    int j, top, mode;

    bus.req_valid    = 1'b0;
    bus.resp_ready   = 1'b0;
    bus.block_switch = 1'b0;
    bus.char_x       = '0;
    bus.char_y       = '0;
    bus.prev_y       = '0;
    clear_lists();
    m_cam = 0; m_cx = 0; m_cy = 0; m_prev = 0;
    drive_lists();

    // Reset with req_valid asserted: reset wins
    sys_rst       = 1'b1;
    bus.req_valid = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    bus.req_valid = 1'b0;
    sys_rst       = 1'b0;
    check("rst.req_ready",  bus.req_ready,  1);
    check("rst.resp_valid", bus.resp_valid, 0);
    check("rst.landed",     bus.landed,     0);
    check("rst.floor",      bus.floor_hit,  0);
    check("rst.hit_idx",    bus.hit_idx,    7);
    check("rst.land_y",     bus.land_y,     0);
`ifdef PLAT_COLLIDE_CEIL_EN
    check("rst.ceil",       bus.ceil_hit,   0);
`endif

    // Basic landing
    clear_lists();
    m_px[0] = 280; m_py[0] = 75; m_pl[0] = 10;
    m_cam = 0; m_cx = 300; m_prev = 80; m_cy = 70;
    do_query("land");
    check("land.idx_const", bus.hit_idx, 0);

    // Highest top wins, then tie keeps lower index
    clear_lists();
    m_px[1] = 100; m_py[1] = 100; m_pl[1] = 8;
    m_px[3] = 100; m_py[3] = 120; m_pl[3] = 8;
    m_cx = 110; m_prev = 130; m_cy = 90;
    do_query("best");
    m_py[3] = 100;
    do_query("tie");

    // Camera offset
    clear_lists();
    m_cam = 2; m_px[2] = 50; m_py[2] = 200; m_pl[2] = 6;
    m_cx = 60; m_prev = 1165; m_cy = 1150;
    do_query("camera");

    // Floor
    clear_lists();
    m_cam = 0; m_cx = 10; m_prev = 5; m_cy = -3;
    do_query("floor");
    m_prev = 5; m_cy = 0;
    do_query("floor0");
    m_prev = 9; m_cy = 1;
    do_query("air");

    // Horizontal edges and exact-equality vertical crossing
    clear_lists();
    m_px[0] = 280; m_py[0] = 75; m_pl[0] = 10;
    m_cx = 264; m_prev = 80; m_cy = 70;
    do_query("edge264");
    m_cx = 265;
    do_query("edge265");
    m_cx = 379;
    do_query("edge379");
    m_cx = 380;
    do_query("edge380");
    m_cx = 300; m_prev = 75; m_cy = 75;
    do_query("flush");

`ifdef PLAT_COLLIDE_CEIL_EN
    clear_lists();
    m_px[4] = 100; m_py[4] = 100; m_pl[4] = 5;
    m_cx = 110; m_prev = 70; m_cy = 85;
    do_query("ceil");
    check("ceil.const", bus.ceil_hit, 1);
`endif

    // Randomized queries aimed around a chosen platform
    for (int t = 0; t < 40; t++) begin
      m_cam = $urandom_range(0, 3);
      for (int i = 0; i < 7; i++) begin
        m_px[i] = $urandom_range(0, 400);
        m_py[i] = $urandom_range(0, 470);
        m_pl[i] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 15);
      end
      j    = $urandom_range(0, 6);
      top  = m_cam * 480 + m_py[j];
      m_cx = m_px[j] + int'($urandom_range(0, m_pl[j] * 10 + 8)) - 12;
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          m_prev = top + int'($urandom_range(0, 20)) - 3;
          m_cy   = top - int'($urandom_range(0, 20)) + 3;
        end
        1: begin
          m_prev = top - 20 - int'($urandom_range(0, 10)) + 2;
          m_cy   = m_prev + int'($urandom_range(1, 30));
        end
        2: begin
          m_prev = int'($urandom_range(0, 12)) - 2;
          m_cy   = int'($urandom_range(0, 10)) - 6;
        end
        default: begin
          m_prev = $urandom_range(0, 2000);
          m_cy   = $urandom_range(0, 2000);
        end
      endcase
      do_query("rand");
    end

    // block_switch during scan: only the new lists count, latency restarts
    clear_lists();
    m_px[0] = 280; m_py[0] = 75; m_pl[0] = 10;
    m_cam = 0; m_cx = 300; m_prev = 1000; m_cy = 50;
    start_query();
    repeat (3) @(posedge sys_clk);
    #1;
    clear_lists();
    m_cam = 1; m_px[5] = 290; m_py[5] = 100; m_pl[5] = 5;
    drive_lists();
    bus.block_switch = 1'b1;
    @(posedge sys_clk); #1;
    bus.block_switch = 1'b0;
    wait_resp("bswitch.latency");
    check_result("bswitch");
    check("bswitch.idx_const", bus.hit_idx, 5);

    // Hold: outputs stable, req ignored, block_switch ignored in DONE
    for (int c = 0; c < 5; c++) begin
      check("hold.resp_valid", bus.resp_valid, 1);
      check("hold.req_ready",  bus.req_ready,  0);
      check("hold.hit_idx",    bus.hit_idx,    e_idx);
      check("hold.land_y",     bus.land_y,     e_y);
      check("hold.landed",     bus.landed,     e_land);
      bus.block_switch = (c == 1);
      bus.req_valid    = (c == 2);
      bus.camera_y     = 6'(3);
      @(posedge sys_clk); #1;
    end
    bus.block_switch = 1'b0;
    bus.req_valid    = 1'b0;
    check_result("hold.after");
    release_resp();

    // Reset mid-scan aborts with no response
    clear_lists();
    m_px[0] = 280; m_py[0] = 75; m_pl[0] = 10;
    m_cam = 0; m_cx = 300; m_prev = 80; m_cy = 70;
    start_query();
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    check("abort.req_ready",  bus.req_ready,  1);
    check("abort.resp_valid", bus.resp_valid, 0);
    check("abort.hit_idx",    bus.hit_idx,    7);
    for (int c = 0; c < 10; c++) begin
      @(posedge sys_clk); #1;
      check("abort.quiet", bus.resp_valid, 0);
    end
    do_query("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
